serial_adder_core: RTL

- Bit-serial WIDTH-bit adder core with valid/ready handshakes on input and output.
- It is the additive counterpart to the team's combinational subtractor datapath. It restores a minuend from a difference plus subtrahend, and computes ordinary sums, at one full-adder of area.
- It sits behind a tt_um_* top-level wrapper. The wrapper maps ui_in/uio_in to the operands, maps uo_out to the sum, and inverts rst_n into rst.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_full_adder_bit.sv | 13 +
 rtl/serial_adder_core.sv | 94 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder core.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Elaboration-time ceil(log2(v)), returning at least 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit combinational full adder; the whole arithmetic datapath of the core.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial unsigned adder: one operand pair per WIDTH+2 cycles, LSB first through one full adder.
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_bit;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_LAST);

  full_adder_bit u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_bit),
    .co (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath: sum bits enter at the MSB so the result is aligned after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_s_sr  <= {w_bit, r_s_sr[WIDTH-1:1]};
      r_carry <= w_carry;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_cout <= w_carry;
    end
  end

  assign sum  = r_s_sr;
  assign cout = r_cout;

endmodule
